goertzel_detector: RTL and testbench

Tone-detection back end placed directly downstream of `GoertzelPower`. It sequences repeated Goertzel windows by pulsing the engine's start input and collects each `power_o` result on `done_o`. Every 2^AVG_LOG2 windows it emits the truncated mean power. A hysteretic, debounced threshold decision on that mean drives a single `detect_o` flag for the receiver control logic.

---
 rtl/goertzel_detector.sv | 120 ++++++++++++
 tb/tb_goertzel_detector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_detector.sv
// Goertzel back end: sequences windows, reports the truncated mean power of every
// 2^AVG_LOG2 windows, and drives a hysteretic, debounced tone-detect flag from that mean.
module goertzel_detector #(
  parameter int unsigned AVG_LOG2   = 2,
  parameter logic [31:0] ON_THRESH  = 32'd1_000_000,
  parameter logic [31:0] OFF_THRESH = 32'd250_000,
  parameter int unsigned HOLD       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        done_i,
  input  logic [31:0] power_i,
  output logic        start_o,
  output logic [31:0] avg_power_o,
  output logic        avg_valid_o,
  output logic        detect_o,
  output logic        detect_changed_o
);
  localparam int unsigned AW = 32 + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_qual;
  logic [31:0]   r_avg;
  logic          r_start, r_avg_valid, r_detect, r_detect_chg;
  logic          w_start_nxt, w_done_acc, w_abort, w_last, w_qualifies, w_hold_hit;
  logic [AW-1:0] w_sum;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable_i) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (done_i)         w_state_nxt = enable_i ? S_START : S_IDLE;
        else if (!enable_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decoded from the next state so start_o leaves a register with no extra latency.
  always_comb begin
    w_start_nxt = (w_state_nxt == S_START);
    w_done_acc  = (r_state == S_WAIT) && done_i;
    w_abort     = (r_state == S_WAIT) && !done_i && !enable_i;
  end

  assign w_last = (r_cnt == LAST_CNT);
  assign w_sum  = r_acc + AW'(power_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start     <= 1'b0;
      r_avg_valid <= 1'b0;
      r_avg       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      r_start     <= w_start_nxt;
      r_avg_valid <= 1'b0;
      if (w_abort) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_done_acc) begin
        if (w_last) begin
          r_avg       <= 32'(w_sum >> AVG_LOG2);
          r_avg_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // A report qualifies when it argues for the opposite of the current decision.
  assign w_qualifies = r_detect ? (r_avg < OFF_THRESH) : (r_avg >= ON_THRESH);
  assign w_hold_hit  = w_qualifies && ((r_qual + 4'd1) == 4'(HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_qual       <= '0;
      r_detect     <= 1'b0;
      r_detect_chg <= 1'b0;
    end else begin
      r_detect_chg <= 1'b0;
      if (r_avg_valid) begin
        if (!w_qualifies) begin
          r_qual <= '0;
        end else if (w_hold_hit) begin
          r_qual       <= '0;
          r_detect     <= ~r_detect;
          r_detect_chg <= 1'b1;
        end else begin
          r_qual <= r_qual + 4'd1;
        end
      end
    end
  end

  assign start_o          = r_start;
  assign avg_power_o      = r_avg;
  assign avg_valid_o      = r_avg_valid;
  assign detect_o         = r_detect;
  assign detect_changed_o = r_detect_chg;
endmodule

// File: tb/tb_goertzel_detector.sv
// Directed + randomized bench: a fake Goertzel engine answers start_o pulses, and a
// queue-based model predicts reports and detect decisions for two parameterisations.
module tb_goertzel_detector;
  localparam logic [31:0] ON  = 32'd1000;
  localparam logic [31:0] OFF = 32'd500;

  logic        clk = 1'b0;
  logic        rst, enable_i, done_i;
  logic [31:0] power_i;
  logic        start1, valid1, det1, chg1;
  logic [31:0] avg1;
  logic        start0, valid0, det0, chg0;
  logic [31:0] avg0;

  always #5 clk = ~clk;

  goertzel_detector #(.AVG_LOG2(2), .ON_THRESH(ON), .OFF_THRESH(OFF), .HOLD(2)) u_dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .done_i(done_i), .power_i(power_i),
    .start_o(start1), .avg_power_o(avg1), .avg_valid_o(valid1),
    .detect_o(det1), .detect_changed_o(chg1));

  goertzel_detector #(.AVG_LOG2(0), .ON_THRESH(ON), .OFF_THRESH(OFF), .HOLD(1)) u_dut0 (
    .clk(clk), .rst(rst), .enable_i(enable_i), .done_i(done_i), .power_i(power_i),
    .start_o(start0), .avg_power_o(avg0), .avg_valid_o(valid0),
    .detect_o(det0), .detect_changed_o(chg0));

  int n_assert = 0;
  int n_fail   = 0;

  longint unsigned set_q[$];
  logic [31:0] m_avg1, m_avg0;
  logic        m_valid1, m_det1, m_det0, m_chg1, m_chg0;
  int          m_run1, m_run0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hyst(input logic [31:0] avg, input int hold, inout logic det,
                      inout int run, output logic chg);
    logic q;
    q   = det ? (avg < OFF) : (avg >= ON);
    chg = 1'b0;
    if (q) run++;
    else   run = 0;
    if (run == hold) begin
      det = ~det;
      chg = 1'b1;
      run = 0;
    end
  endtask

  task automatic model_reset();
    set_q.delete();
    m_avg1 = '0; m_avg0 = '0; m_valid1 = 1'b0;
    m_det1 = 1'b0; m_det0 = 1'b0; m_chg1 = 1'b0; m_chg0 = 1'b0;
    m_run1 = 0; m_run0 = 0;
  endtask

  task automatic model_done(input logic [31:0] p);
    longint unsigned s;
    s = 0;
    set_q.push_back(p);
    m_valid1 = 1'b0;
    m_chg1   = 1'b0;
    if (set_q.size() == 4) begin
      foreach (set_q[i]) s += set_q[i];
      m_avg1   = 32'(s / 4);
      m_valid1 = 1'b1;
      set_q.delete();
      hyst(m_avg1, 2, m_det1, m_run1, m_chg1);
    end
    m_avg0 = p;
    hyst(p, 1, m_det0, m_run0, m_chg0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start"}, start1, 0);  check({tag, "_valid"}, valid1, 0);
    check({tag, "_avg"},   avg1, 0);    check({tag, "_det"},   det1, 0);
    check({tag, "_chg"},   chg1, 0);    check({tag, "_start0"}, start0, 0);
    check({tag, "_avg0"},  avg0, 0);    check({tag, "_det0"},  det0, 0);
  endtask

  // Called in the cycle two after a done_i: detect decisions land here.
  task automatic check_detect();
    check("detect", det1, m_det1);   check("detect_chg", chg1, m_chg1);
    check("detect0", det0, m_det0);  check("detect_chg0", chg0, m_chg0);
    m_chg1 = 1'b0;
    m_chg0 = 1'b0;
  endtask

  task automatic begin_run();
    check("start_idle", start1, 0);
    enable_i = 1'b1;
    tick();
    check("start_first", start1, 1);
    check("start_first0", start0, 1);
  endtask

  // Entered in the START cycle; leaves in the next START cycle (en=1) or idle (en=0).
  task automatic do_window(input logic [31:0] p, input bit en);
    int lat;
    lat = int'($urandom_range(1, 4));
    tick();
    check("start_gap", start1, 0);
    check_detect();
    for (int i = 1; i < lat; i++) begin
      tick();
      check("start_wait", start1, 0);
      check("valid_wait", valid1, 0);
      check("chg_wait", chg1, 0);
    end
    done_i = 1'b1; power_i = p; enable_i = en;
    model_done(p);
    tick();
    done_i = 1'b0; power_i = $urandom;
    check("start_next", start1, en);   check("start_next0", start0, en);
    check("avg_valid", valid1, m_valid1);
    check("avg_power", avg1, m_avg1);
    check("avg_valid0", valid0, 1);    check("avg_power0", avg0, m_avg0);
    if (!en) begin
      tick();
      check("start_stop", start1, 0);
      check_detect();
    end
  endtask

  task automatic send_report(input logic [31:0] target, input bit en_last);
    int unsigned total, a, b, c;
    total = 4 * target + $urandom_range(0, 3);
    a = $urandom_range(0, total);
    b = $urandom_range(0, total - a);
    c = $urandom_range(0, total - a - b);
    do_window(a, 1'b1);
    do_window(b, 1'b1);
    do_window(c, 1'b1);
    do_window(total - a - b - c, en_last);
  endtask

  initial begin
    rst = 1'b1; enable_i = 1'b0; done_i = 1'b0; power_i = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    check_outputs_zero("reset");
    tick();

    begin_run();
    do_window(100, 1); do_window(200, 1); do_window(300, 1); do_window(400, 1);
    do_window(32'hFFFF_FFFF, 1); do_window(32'hFFFF_FFFF, 1);
    do_window(32'hFFFF_FFFF, 1); do_window(32'hFFFF_FFFF, 1);
    do_window(1, 1); do_window(1, 1); do_window(1, 1); do_window(0, 1);

    send_report(1200, 1); send_report(700, 1); send_report(1200, 1); send_report(1200, 1);
    send_report(400, 1);  send_report(600, 1); send_report(400, 1);  send_report(400, 1);

    // Abort after two windows, then a stray done_i while idle.
    do_window(3000, 1); do_window(3000, 1);
    tick();
    check_detect();
    enable_i = 1'b0;
    tick();
    check("start_abort", start1, 0);
    set_q.delete();
    done_i = 1'b1; power_i = 32'd50_000;
    tick();
    done_i = 1'b0;
    check("valid_stray", valid1, 0);
    check("valid_stray0", valid0, 0);
    check("avg_stray0", avg0, m_avg0);
    tick();
    check("start_stray", start1, 0);
    begin_run();
    do_window(10, 1); do_window(20, 1); do_window(30, 1); do_window(40, 1);

    // Reset mid-window with detect set and a nonzero accumulator.
    send_report(1200, 1); send_report(1200, 1);
    do_window(5000, 1);
    tick();
    check_detect();
    check("pre_reset_detect", det1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; enable_i = 1'b0;
    model_reset();
    check_outputs_zero("midreset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("start_after_reset", start1, 0);
    end
    begin_run();

    for (int i = 0; i < 12; i++) send_report($urandom_range(0, 1500), 1);
    send_report($urandom_range(0, 1500), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
